// File: rtl/spi_config_assembler_if.sv
// Byte-stream and commit signals between the SPI byte receiver, the config
// assembler and the VGA pixel path.
interface spi_config_assembler_if #(
  parameter int unsigned CFG_WIDTH = 32
);
  logic                 ss;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 vblank_pulse;
  logic [CFG_WIDTH-1:0] config_out;
  logic                 config_update;
  logic [7:0]           status;
  logic [7:0]           err_cnt;

  modport master (
    output ss, byte_valid, byte_data, vblank_pulse,
    input  config_out, config_update, status, err_cnt
  );

  modport slave (
    input  ss, byte_valid, byte_data, vblank_pulse,
    output config_out, config_update, status, err_cnt
  );
endinterface

// File: rtl/spi_config_assembler.sv
// Assembles one SPI frame (MSB byte first) into a config word, validates its length and
// commits it to config_out at vertical blank so the screen mode never changes mid-frame.
module spi_config_assembler #(
  parameter int unsigned          CFG_WIDTH      = 32,
  parameter logic [CFG_WIDTH-1:0] RESET_CFG      = 32'h80FC_0000,
  parameter bit                   SYNC_TO_VBLANK = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  spi_config_assembler_if.slave io_bus
);

  localparam int unsigned Bytes = CFG_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(Bytes + 1);

  typedef enum logic {StIdle, StCollect} state_e;

  state_e               r_state, w_state_d;
  logic                 r_ss_q;
  logic [CFG_WIDTH-1:0] r_shadow, w_shadow_d;
  logic [CFG_WIDTH-1:0] r_staged, w_staged_d;
  logic [CFG_WIDTH-1:0] r_cfg, w_cfg_d;
  logic                 r_update, w_update_d;
  logic [CntW-1:0]      r_byte_cnt, w_byte_cnt_d;
  logic                 r_pending, w_pending_d;
  logic                 r_last_err, w_last_err_d;
  logic                 r_overrun, w_overrun_d;
  logic [7:0]           r_err_cnt, w_err_cnt_d;

  logic                 w_frame_end;
  logic                 w_vblank;
  logic                 w_commit;
  logic [2:0]           w_cnt3;

  assign w_frame_end = io_bus.ss & ~r_ss_q;
  assign w_vblank    = SYNC_TO_VBLANK ? io_bus.vblank_pulse : 1'b1;
  // Commit looks at pending before the edge, so a colliding good frame stays staged.
  assign w_commit    = w_vblank & r_pending;

  always_comb begin
    w_state_d    = r_state;
    w_shadow_d   = r_shadow;
    w_staged_d   = r_staged;
    w_cfg_d      = r_cfg;
    w_update_d   = 1'b0;
    w_byte_cnt_d = r_byte_cnt;
    w_pending_d  = r_pending;
    w_last_err_d = r_last_err;
    w_overrun_d  = r_overrun;
    w_err_cnt_d  = r_err_cnt;

    if (w_commit) begin
      w_cfg_d     = r_staged;
      w_pending_d = 1'b0;
      w_update_d  = 1'b1;
    end

    case (r_state)
      StIdle: begin
        if (!io_bus.ss) begin
          w_state_d    = StCollect;
          w_byte_cnt_d = '0;
          w_overrun_d  = 1'b0;
          w_shadow_d   = '0;
        end
      end
      StCollect: begin
        if (w_frame_end) begin
          w_state_d = StIdle;
          if (r_byte_cnt == CntW'(Bytes) && !r_overrun) begin
            w_staged_d   = r_shadow;
            w_pending_d  = 1'b1;
            w_last_err_d = 1'b0;
          end else begin
            w_last_err_d = 1'b1;
            if (r_err_cnt != 8'hFF) w_err_cnt_d = r_err_cnt + 8'd1;
          end
        end else if (io_bus.byte_valid && !io_bus.ss) begin
          if (r_byte_cnt < CntW'(Bytes)) begin
            w_shadow_d   = {r_shadow[CFG_WIDTH-9:0], io_bus.byte_data};
            w_byte_cnt_d = r_byte_cnt + CntW'(1);
          end else begin
            w_overrun_d = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_ss_q     <= 1'b1;
      r_shadow   <= '0;
      r_staged   <= '0;
      r_cfg      <= RESET_CFG;
      r_update   <= 1'b0;
      r_byte_cnt <= '0;
      r_pending  <= 1'b0;
      r_last_err <= 1'b0;
      r_overrun  <= 1'b0;
      r_err_cnt  <= 8'h00;
    end else begin
      r_state    <= w_state_d;
      r_ss_q     <= io_bus.ss;
      r_shadow   <= w_shadow_d;
      r_staged   <= w_staged_d;
      r_cfg      <= w_cfg_d;
      r_update   <= w_update_d;
      r_byte_cnt <= w_byte_cnt_d;
      r_pending  <= w_pending_d;
      r_last_err <= w_last_err_d;
      r_overrun  <= w_overrun_d;
      r_err_cnt  <= w_err_cnt_d;
    end
  end

  assign w_cnt3               = 3'(r_byte_cnt);
  assign io_bus.config_out    = r_cfg;
  assign io_bus.config_update = r_update;
  assign io_bus.status        = {r_pending, r_last_err, 3'b000, w_cnt3};
  assign io_bus.err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_spi_config_assembler.sv
// Directed bench for spi_config_assembler: expected commits go into a queue that a
// negedge monitor pops on every config_update pulse; state checks are direct.
module tb_spi_config_assembler;

  localparam logic [31:0] ResetCfg = 32'h80FC_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];

  spi_config_assembler_if #(.CFG_WIDTH(32)) bus ();

  spi_config_assembler #(
    .CFG_WIDTH     (32),
    .RESET_CFG     (ResetCfg),
    .SYNC_TO_VBLANK(1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every update pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (!rst && bus.config_update === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_update: got %h expected no update", bus.config_out);
      end else begin
        check("commit", bus.config_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bytes taken MSB-first from the top of data; optional vblank in the frame_end cycle.
  task automatic send_frame(input logic [63:0] data, input int n, input bit vb_at_end);
    bus.ss = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = data[63-8*i -: 8];
      tick();
      bus.byte_valid = 1'b0;
      tick();
    end
    bus.ss           = 1'b1;
    bus.vblank_pulse = vb_at_end;
    tick();
    bus.vblank_pulse = 1'b0;
    tick();
  endtask

  task automatic vblank();
    bus.vblank_pulse = 1'b1;
    tick();
    bus.vblank_pulse = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ss           = 1'b1;
    bus.byte_valid   = 1'b0;
    bus.byte_data    = 8'h00;
    bus.vblank_pulse = 1'b0;

    // T1 reset
    #23;
    check("rst_cfg", bus.config_out, ResetCfg);
    check("rst_status", {24'h0, bus.status}, 32'h00);
    check("rst_err", {24'h0, bus.err_cnt}, 32'h00);
    check("rst_update", {31'h0, bus.config_update}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // T2 good frame
    send_frame(64'h12345678_00000000, 4, 1'b0);
    check("t2_status_pre", {24'h0, bus.status}, 32'h84);
    exp_q.push_back(32'h12345678);
    vblank();
    check("t2_cfg", bus.config_out, 32'h12345678);
    check("t2_pending", {31'h0, bus.status[7]}, 32'h0);
    vblank();

    // T3 short then overrun
    send_frame(64'h11223300_00000000, 3, 1'b0);
    check("t3_err1", {24'h0, bus.err_cnt}, 32'h01);
    check("t3_status_short", {24'h0, bus.status}, 32'h43);
    vblank();
    check("t3_cfg_short", bus.config_out, 32'h12345678);
    send_frame(64'hAABBCCDD_EE000000, 5, 1'b0);
    check("t3_err2", {24'h0, bus.err_cnt}, 32'h02);
    check("t3_status_over", {24'h0, bus.status}, 32'h44);
    vblank();
    check("t3_cfg_over", bus.config_out, 32'h12345678);

    // T4 latest wins
    send_frame(64'hA1B2C3D4_00000000, 4, 1'b0);
    send_frame(64'h01020304_00000000, 4, 1'b0);
    check("t4_status", {24'h0, bus.status}, 32'h84);
    exp_q.push_back(32'h01020304);
    vblank();
    check("t4_cfg", bus.config_out, 32'h01020304);
    vblank();

    // T5 collision: X pending, Y ends in the vblank cycle
    send_frame(64'hCAFEBABE_00000000, 4, 1'b0);
    exp_q.push_back(32'hCAFEBABE);
    send_frame(64'h0BADF00D_00000000, 4, 1'b1);
    check("t5_cfg_x", bus.config_out, 32'hCAFEBABE);
    check("t5_pending_y", {31'h0, bus.status[7]}, 32'h1);
    exp_q.push_back(32'h0BADF00D);
    vblank();
    check("t5_cfg_y", bus.config_out, 32'h0BADF00D);

    // T6 async reset mid-frame after 2 bytes
    bus.ss = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h77 + 8'(i);
      tick();
      bus.byte_valid = 1'b0;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("t6_cfg", bus.config_out, ResetCfg);
    check("t6_status", {24'h0, bus.status}, 32'h00);
    check("t6_err", {24'h0, bus.err_cnt}, 32'h00);
    bus.ss = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    send_frame(64'h55AA33CC_00000000, 4, 1'b0);
    check("t6_status_post", {24'h0, bus.status}, 32'h84);
    exp_q.push_back(32'h55AA33CC);
    vblank();
    check("t6_cfg_post", bus.config_out, 32'h55AA33CC);
    vblank();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
